serial_mult_harness: RTL

- Parametrised serial-load multiplier harness for timing and DSP-mapping characterisation of A_W x B_W multipliers.
- Operands are shifted in one bit per valid cycle, MSB first.
- Each completed frame launches one multiply into a PIPE-deep register pipeline. The product is registered out with its XOR-parity bit and a valid strobe.
- Sits at the top of the mm characterisation builds, so one pin pair drives arbitrary multiplier widths and pipeline depths.

---
 rtl/serial_mult_harness.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_mult_harness.sv
// Serial-load multiplier harness: operands arrive one bit per valid cycle (MSB first), each
// completed frame launches a multiply into a PIPE-deep pipeline, and the product is registered
// out with its XOR parity, a valid strobe and a saturating result counter.
// Optional build macro: SERIAL_MULT_SIGNED_EN (two's complement operands when defined).
module serial_mult_harness #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 16,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld_i,
  input  logic               a_i,
  input  logic               b_i,
  output logic               p_o,
  output logic [A_W+B_W-1:0] prod_o,
  output logic               p_vld_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   result_cnt_o
);

  localparam int unsigned N  = (A_W > B_W) ? A_W : B_W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = A_W + B_W;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  // Post-shift operand values: what the registers will hold once this cycle's bit is taken.
  logic [A_W-1:0] a_sr_d;
  logic [B_W-1:0] b_sr_d;

  // Only the low W-1 bits need storing; the MSB falls out on the next shift anyway.
  if (A_W > 1) begin : g_a_sr
    logic [A_W-2:0] a_hist_q;
    // Shift history for operand A
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_hist_q <= '0;
      end else if (in_vld_i) begin
        a_hist_q <= a_sr_d[A_W-2:0];
      end
    end
    assign a_sr_d = {a_hist_q, a_i};
  end else begin : g_a_bit
    assign a_sr_d = a_i;
  end

  if (B_W > 1) begin : g_b_sr
    logic [B_W-2:0] b_hist_q;
    // Shift history for operand B
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b_hist_q <= '0;
      end else if (in_vld_i) begin
        b_hist_q <= b_sr_d[B_W-2:0];
      end
    end
    assign b_sr_d = {b_hist_q, b_i};
  end else begin : g_b_bit
    assign b_sr_d = b_i;
  end

  logic [CW-1:0]    bit_cnt_q;
  logic [A_W-1:0]   op_a_q;
  logic [B_W-1:0]   op_b_q;
  logic             v0_q;
  logic [PW-1:0]    stage_q [PIPE];
  logic [PIPE-1:0]  v_q;
  logic [PW-1:0]    prod_q;
  logic             p_q;
  logic             p_vld_q;
  logic [CNT_W-1:0] result_cnt_q;

  logic             launch;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    mult;

  assign launch = in_vld_i && (bit_cnt_q == LastCnt);

  // Extend operands to full product width; low PW bits of the product are then exact.
  always_comb begin
`ifdef SERIAL_MULT_SIGNED_EN
    a_ext = {{B_W{op_a_q[A_W-1]}}, op_a_q};
    b_ext = {{A_W{op_b_q[B_W-1]}}, op_b_q};
`else
    a_ext = {{B_W{1'b0}}, op_a_q};
    b_ext = {{A_W{1'b0}}, op_b_q};
`endif
    mult = a_ext * b_ext;
  end

  // Frame counter, operand snapshot, multiplier pipeline, output registers and result counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      v0_q         <= 1'b0;
      v_q          <= '0;
      for (int k = 0; k < PIPE; k++) stage_q[k] <= '0;
      prod_q       <= '0;
      p_q          <= 1'b0;
      p_vld_q      <= 1'b0;
      result_cnt_q <= '0;
    end else begin
      if (in_vld_i) begin
        bit_cnt_q <= launch ? '0 : bit_cnt_q + CW'(1);
      end
      if (launch) begin
        op_a_q <= a_sr_d;
        op_b_q <= b_sr_d;
      end
      v0_q <= launch;

      stage_q[0] <= mult;
      v_q[0]     <= v0_q;
      for (int k = 1; k < PIPE; k++) begin
        stage_q[k] <= stage_q[k-1];
        v_q[k]     <= v_q[k-1];
      end

      // Outputs hold the last result between strobes
      p_vld_q <= v_q[PIPE-1];
      if (v_q[PIPE-1]) begin
        prod_q <= stage_q[PIPE-1];
        p_q    <= ^stage_q[PIPE-1];
        if (result_cnt_q != '1) result_cnt_q <= result_cnt_q + CNT_W'(1);
      end
    end
  end

  assign p_o          = p_q;
  assign prod_o       = prod_q;
  assign p_vld_o      = p_vld_q;
  assign result_cnt_o = result_cnt_q;
  assign busy_o       = (bit_cnt_q != '0) | v0_q | (|v_q);

endmodule
